channel_mixer: RTL and testbench

CHANNEL_MIXER -- requirements
Module: channel_mixer

---
 rtl/channel_mixer.sv | 182 ++++++++++++++++++
 tb/tb_channel_mixer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/channel_mixer.sv
// rtl/channel_mixer.sv - multi-channel volume-scaled mixer with saturation and optional sigma-delta DAC
//
// Purpose: on each accepted sample strobe, latches all channel samples, volumes
// and mutes, then scales each channel by its 4-bit volume with a serial
// shift-add multiplier (volume/16), sums the unmuted channels and registers the
// saturated result. Fixed latency of 5*NUM_CHANNELS+2 cycles from strobe to valid.
//
// Optional feature macro: CHANNEL_MIXER_SIGMA_DELTA_EN
//   defined   -> o_dac is a first-order sigma-delta bitstream of o_mix
//   undefined -> o_dac is tied to 0 and no modulator logic exists
//
// Ports:
//   i_clk        clock, all logic on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_sample_stb one-cycle output-sample-rate strobe
//   i_samples    NUM_CHANNELS x SAMPLE_WIDTH packed samples, channel 0 in LSBs
//   i_volumes    NUM_CHANNELS x 4 packed volumes, channel 0 in LSBs
//   i_mute       per-channel mute, bit c mutes channel c
//   o_mix        registered saturated mix, held between updates
//   o_mix_valid  one-cycle pulse when o_mix updates
//   o_busy       high while a mix is in progress
//   o_overrun    one-cycle pulse after a strobe arrives while busy
//   o_dac        sigma-delta bitstream (0 when the modulator is not built)
module channel_mixer #(
   parameter int NUM_CHANNELS = 4,
   parameter int SAMPLE_WIDTH = 9,
   parameter int OUT_WIDTH    = 10
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_sample_stb,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
   input  logic [NUM_CHANNELS*4-1:0]            i_volumes,
   input  logic [NUM_CHANNELS-1:0]              i_mute,
   output logic [OUT_WIDTH-1:0]                 o_mix,
   output logic                                 o_mix_valid,
   output logic                                 o_busy,
   output logic                                 o_overrun,
   output logic                                 o_dac
);

   localparam int PW   = SAMPLE_WIDTH + 4;
   localparam int AW   = SAMPLE_WIDTH + 3;
   localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int CW   = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;

   localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CHANNELS - 1);
   localparam logic [CW-1:0]   MAX_EXT = {{(CW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_ACC, S_DONE} state_t;

   state_t                            r_state;
   state_t                            w_next;
   logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] r_samples;
   logic [NUM_CHANNELS*4-1:0]         r_volumes;
   logic [NUM_CHANNELS-1:0]           r_mute;
   logic [PW-1:0]                     r_prod;
   logic [AW-1:0]                     r_acc;
   logic [CH_W-1:0]                   r_ch;
   logic [1:0]                        r_bit;
   logic [OUT_WIDTH-1:0]              r_mix;
   logic                              r_mix_valid;
   logic                              r_overrun;

   logic [SAMPLE_WIDTH-1:0]           w_sample;
   logic [3:0]                        w_vol;
   logic                              w_muted;
   logic                              w_last;
   logic [PW-1:0]                     w_addend;
   logic [AW-1:0]                     w_scaled;
   logic [CW-1:0]                     w_acc_ext;
   logic [OUT_WIDTH-1:0]              w_sat;

   // Select the current channel's latched sample, volume and mute bit.
   always_comb begin
      w_sample = '0;
      w_vol    = '0;
      w_muted  = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (r_ch == CH_W'(c)) begin
            w_sample = r_samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            w_vol    = r_volumes[c*4 +: 4];
            w_muted  = r_mute[c];
         end
      end
   end

   assign w_last    = (r_ch == CH_LAST);
   assign w_addend  = {4'b0000, w_sample} << r_bit;
   // Dividing by 16 makes volume 15 slightly below unity; the truncation is per channel.
   assign w_scaled  = {3'b000, r_prod[PW-1:4]};
   assign w_acc_ext = CW'(r_acc);
   assign w_sat     = (w_acc_ext > MAX_EXT) ? {OUT_WIDTH{1'b1}} : w_acc_ext[OUT_WIDTH-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_sample_stb) w_next = S_MULT;
         S_MULT:  if (r_bit == 2'd3) w_next = S_ACC;
         S_ACC:   w_next = w_last ? S_DONE : S_MULT;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_samples   <= '0;
         r_volumes   <= '0;
         r_mute      <= '0;
         r_prod      <= '0;
         r_acc       <= '0;
         r_ch        <= '0;
         r_bit       <= '0;
         r_mix       <= '0;
         r_mix_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_mix_valid <= (r_state == S_DONE);
         // A strobe arriving in any non-idle state is dropped and flagged.
         r_overrun   <= i_sample_stb && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (i_sample_stb) begin
                  r_samples <= i_samples;
                  r_volumes <= i_volumes;
                  r_mute    <= i_mute;
                  r_prod    <= '0;
                  r_acc     <= '0;
                  r_ch      <= '0;
                  r_bit     <= '0;
               end
            end
            S_MULT: begin
               if (w_vol[r_bit]) r_prod <= r_prod + w_addend;
               r_bit <= r_bit + 2'd1;
            end
            S_ACC: begin
               if (!w_muted) r_acc <= r_acc + w_scaled;
               r_prod <= '0;
               r_ch   <= r_ch + CH_ONE;
            end
            S_DONE: begin
               r_mix <= w_sat;
            end
            default: ;
         endcase
      end
   end

   assign o_mix       = r_mix;
   assign o_mix_valid = r_mix_valid;
   assign o_busy      = (r_state != S_IDLE);
   assign o_overrun   = r_overrun;

`ifdef CHANNEL_MIXER_SIGMA_DELTA_EN
   // Carry out of the modulator accumulator; its density tracks o_mix / 2^OUT_WIDTH.
   logic [OUT_WIDTH:0] r_sd_acc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sd_acc <= '0;
      end else begin
         r_sd_acc <= {1'b0, r_sd_acc[OUT_WIDTH-1:0]} + {1'b0, r_mix};
      end
   end

   assign o_dac = r_sd_acc[OUT_WIDTH];
`else
   assign o_dac = 1'b0;
`endif

endmodule

// File: tb/tb_channel_mixer.sv
// tb/tb_channel_mixer.sv - self-checking bench for channel_mixer
module tb_channel_mixer;

   localparam int NC  = 4;
   localparam int SW  = 9;
   localparam int OW  = 10;
   localparam int LAT = 5*NC + 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              stb = 1'b0;
   logic [NC*SW-1:0]  samples = '0;
   logic [NC*4-1:0]   vols = '0;
   logic [NC-1:0]     mute = '0;
   logic [OW-1:0]     o_mix;
   logic              o_mix_valid;
   logic              o_busy;
   logic              o_overrun;
   logic              o_dac;

   int n_checks = 0;
   int n_err = 0;

   channel_mixer #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .OUT_WIDTH(OW)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sample_stb (stb),
      .i_samples    (samples),
      .i_volumes    (vols),
      .i_mute       (mute),
      .o_mix        (o_mix),
      .o_mix_valid  (o_mix_valid),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun),
      .o_dac        (o_dac)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Mix = sum over unmuted channels of floor(sample*volume/16), clipped to OW bits.
   function automatic int mix_model(input logic [NC*SW-1:0] s, input logic [NC*4-1:0] v,
                                    input logic [NC-1:0] m);
      int sum = 0;
      for (int c = 0; c < NC; c++)
         if (!m[c]) sum += (int'(s[c*SW +: SW]) * int'(v[c*4 +: 4])) / 16;
      return (sum > (1 << OW) - 1) ? (1 << OW) - 1 : sum;
   endfunction

   // Transaction-level model: a strobe is taken whenever the previous mix has
   // delivered its result (or never started), otherwise it is an overrun.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int free_at = 0;
   int start_at = 0;
   int ovr_at = -1;
   int pend_val = 0;
   int exp_mix = 0;
   bit has_start = 0;
   bit pending = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_at = 0; has_start = 0; pending = 0; ovr_at = -1; exp_mix = 0;
      end else if (stb) begin
         if (cyc >= free_at) begin
            start_at = cyc; has_start = 1; free_at = cyc + LAT;
            pending = 1; pend_val = mix_model(samples, vols, mute);
         end else begin
            ovr_at = cyc + 1;
         end
      end
   end

   always @(negedge clk) begin
      bit exp_valid, exp_busy, exp_ovr;
      exp_valid = rst_n && pending && (cyc == free_at);
      if (exp_valid) begin
         exp_mix = pend_val;
         pending = 0;
      end
      exp_busy = rst_n && has_start && (cyc > start_at) && (cyc < free_at);
      exp_ovr  = rst_n && (cyc == ovr_at);
      chk("valid", 32'(o_mix_valid), 32'(exp_valid));
      chk("mix", 32'(o_mix), 32'(exp_mix));
      chk("busy", 32'(o_busy), 32'(exp_busy));
      chk("overrun", 32'(o_overrun), 32'(exp_ovr));
`ifndef CHANNEL_MIXER_SIGMA_DELTA_EN
      chk("dac_off", 32'(o_dac), 32'd0);
`else
      if (!rst_n) chk("dac_rst", 32'(o_dac), 32'd0);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Strobe in cycle 0, then check the result literally in cycle LAT.
   task automatic run_mix(input logic [NC*SW-1:0] s, input logic [NC*4-1:0] v,
                          input logic [NC-1:0] m, input int exp, input string name);
      samples = s; vols = v; mute = m;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      repeat (LAT - 1) tick();
      chk({name, "_valid"}, 32'(o_mix_valid), 32'd1);
      chk({name, "_mix"}, 32'(o_mix), 32'(exp));
      repeat (2) tick();
   endtask

   logic [NC*SW-1:0] s_mixed;
   logic [NC*4-1:0]  v_mixed;
   int dac_ones;

   initial begin
      s_mixed = {9'd50, 9'd511, 9'd300, 9'd10};
      v_mixed = {4'd3, 4'd15, 4'd7, 4'd1};
      repeat (3) tick();
      chk("rst_mix", 32'(o_mix), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      chk("model_960", mix_model({4{9'd256}}, {4{4'd15}}, 4'b0000), 960);
      chk("model_619", mix_model(s_mixed, v_mixed, 4'b0000), 619);
      chk("model_sat", mix_model({4{9'd511}}, {4{4'd15}}, 4'b0000), 1023);

      run_mix({4{9'd256}}, {4{4'd15}}, 4'b0000, 960, "full_vol");
      run_mix({4{9'd511}}, {4{4'd15}}, 4'b0000, 1023, "saturate");
      run_mix({4{9'd100}}, {4{4'd8}}, 4'b0110, 100, "mute");
      run_mix({4{9'd100}}, {4{4'd0}}, 4'b0110, 0, "zero_vol");
      run_mix(s_mixed, v_mixed, 4'b0000, 619, "mixed");

      // Overrun: strobe at 0, inputs changed at 5, strobe at 10, strobe at 22.
      samples = {4{9'd256}}; vols = {4{4'd15}}; mute = '0;
      stb = 1'b1; tick(); stb = 1'b0;
      repeat (4) tick();
      samples = {4{9'd200}};
      repeat (5) tick();
      stb = 1'b1; tick(); stb = 1'b0;
      chk("ovr_pulse", 32'(o_overrun), 32'd1);
      repeat (11) tick();
      chk("ovr_valid22", 32'(o_mix_valid), 32'd1);
      chk("ovr_mix_kept", 32'(o_mix), 32'd960);
      stb = 1'b1; tick(); stb = 1'b0;
      chk("ovr_no_pulse", 32'(o_overrun), 32'd0);
      repeat (21) tick();
      chk("ovr_valid44", 32'(o_mix_valid), 32'd1);
      chk("ovr_mix2", 32'(o_mix), 32'd748);
      repeat (2) tick();

      // Reset in cycle 12 of a mix.
      samples = {4{9'd256}};
      stb = 1'b1; tick(); stb = 1'b0;
      repeat (11) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_mix", 32'(o_mix), 32'd0);
      chk("mid_rst_valid", 32'(o_mix_valid), 32'd0);
      chk("mid_rst_busy", 32'(o_busy), 32'd0);
      chk("mid_rst_ovr", 32'(o_overrun), 32'd0);
      chk("mid_rst_dac", 32'(o_dac), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (12) tick();
      chk("post_rst_idle", 32'(o_busy), 32'd0);
      run_mix(s_mixed, v_mixed, 4'b0000, 619, "post_rst");

      // Sigma-delta density with o_mix = 512.
      run_mix({4{9'd256}}, {4{4'd8}}, 4'b0000, 512, "half");
      repeat (2) tick();
      dac_ones = 0;
      for (int i = 0; i < 1024; i++) begin
         if (o_dac) dac_ones++;
         tick();
      end
`ifdef CHANNEL_MIXER_SIGMA_DELTA_EN
      chk("dac_density", 32'(dac_ones), 32'd512);
`else
      chk("dac_density", 32'(dac_ones), 32'd0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
